// File: rtl/ofmap_packer.sv
// Ofmap write-back packer: four PPU bytes per 32-bit global-buffer write, little-endian.
// Latency: the word whose final byte is accepted in cycle N is valid at N+1.
// Backpressure: a stalled output word (glb_valid && !glb_ready) holds in_ready low.
// Optional feature: define OFMAP_PACKER_PARTIAL_STRB_EN to strobe only the filled lanes of a tile's tail word.
module ofmap_packer #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  total_bytes,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              glb_valid,
    input  logic              glb_ready,
    output logic [ADDR_W-1:0] glb_addr,
    output logic [31:0]       glb_wdata,
    output logic [3:0]        glb_strb,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PACK  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remain_q;
    logic [1:0]        idx_q;
    logic [31:0]       asm_q;

    logic              accept;
    logic              last_byte;
    logic              emit;
    logic [31:0]       merged;
    logic [3:0]        word_strb;

    // Handshake decode and the assembly word with the incoming byte merged into its lane
    always_comb begin
        in_ready  = (state == S_PACK) && (!glb_valid || glb_ready);
        accept    = in_valid && in_ready;
        last_byte = (remain_q == CNT_W'(1));
        emit      = accept && ((idx_q == 2'd3) || last_byte);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        merged    = asm_q;
        merged[8*idx_q +: 8] = in_data;
    end

    // Strobes for the word being emitted; a full word always writes all four lanes
    always_comb begin
        word_strb = 4'hF;
`ifdef OFMAP_PACKER_PARTIAL_STRB_EN
        case (idx_q)
            2'd0:    word_strb = 4'b0001;
            2'd1:    word_strb = 4'b0011;
            2'd2:    word_strb = 4'b0111;
            default: word_strb = 4'b1111;
        endcase
`endif
    end

    // Tile control: state, address, remaining-byte count, lane index and assembly word
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            idx_q    <= 2'd0;
            asm_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= total_bytes;
                        idx_q    <= 2'd0;
                        asm_q    <= '0;
                        // An empty tile passes through DRAIN with nothing pending,
                        // which places its done pulse two cycles after start.
                        state    <= (total_bytes == '0) ? S_DRAIN : S_PACK;
                    end
                end
                S_PACK: begin
                    if (accept) begin
                        idx_q    <= idx_q + 2'd1;
                        remain_q <= remain_q - CNT_W'(1);
                        if (emit) begin
                            addr_q <= addr_q + ADDR_W'(4);
                            asm_q  <= '0;
                        end else begin
                            asm_q  <= merged;
                        end
                        if (last_byte) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!glb_valid || glb_ready) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output word register: load on emit, otherwise release after the buffer handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            glb_valid <= 1'b0;
            glb_addr  <= '0;
            glb_wdata <= '0;
            glb_strb  <= '0;
        end else if (emit) begin
            glb_valid <= 1'b1;
            glb_addr  <= addr_q;
            glb_wdata <= merged;
            glb_strb  <= word_strb;
        end else if (glb_ready) begin
            glb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofmap_packer.sv
// Self-checking bench for ofmap_packer: random tiles against a word-level reference model.
// Expected writes are derived from the byte list of each tile; a monitor checks every write.
// Covers reset values, backpressure hold, zero-length tile, ignored start, mid-tile reset, address wrap.
module tb_ofmap_packer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] total_bytes;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        glb_valid;
    logic        glb_ready;
    logic [31:0] glb_addr;
    logic [31:0] glb_wdata;
    logic [3:0]  glb_strb;
    logic        busy;
    logic        done;

    logic        w_start;
    logic [7:0]  w_base;
    logic [15:0] w_total;
    logic        w_in_valid;
    logic [7:0]  w_in_data;
    logic        w_in_ready;
    logic        w_glb_valid;
    logic        w_glb_ready;
    logic [7:0]  w_glb_addr;
    logic [31:0] w_glb_wdata;
    logic [3:0]  w_glb_strb;
    logic        w_busy;
    logic        w_done;

    ofmap_packer #(.ADDR_W(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .total_bytes(total_bytes), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .glb_valid(glb_valid), .glb_ready(glb_ready),
        .glb_addr(glb_addr), .glb_wdata(glb_wdata), .glb_strb(glb_strb),
        .busy(busy), .done(done)
    );

    ofmap_packer #(.ADDR_W(8), .CNT_W(16)) u_wrap (
        .clk(clk), .rst(rst), .start(w_start), .base_addr(w_base),
        .total_bytes(w_total), .in_valid(w_in_valid), .in_data(w_in_data),
        .in_ready(w_in_ready), .glb_valid(w_glb_valid), .glb_ready(w_glb_ready),
        .glb_addr(w_glb_addr), .glb_wdata(w_glb_wdata), .glb_strb(w_glb_strb),
        .busy(w_busy), .done(w_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests     = 0;
    int  n_fail      = 0;
    int  cyc         = 0;
    int  exp_done_at = -10;
    int  valid_due   = -10;
    int  done_cnt    = 0;
    bit  mon_en      = 1'b0;
    int  rmode       = 0;
    int  stall_left  = 0;
    bit  stall_armed = 1'b0;

    int          wn;
    int          wk;
    logic [7:0]  wa [2];
    logic [31:0] wd [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Buffer-side ready generator: always ready, random, or a single 5-cycle stall on the first word
    initial begin
        glb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: glb_ready = 1'b1;
                1: glb_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_armed && glb_valid) begin
                        stall_left  = 5;
                        stall_armed = 1'b0;
                    end
                    if (stall_left > 0) begin
                        glb_ready = 1'b0;
                        stall_left--;
                    end else begin
                        glb_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Write monitor: every valid word must match the head of the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (glb_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_write", {31'b0, glb_valid}, 32'd0);
                    end else begin
                        check("wr_addr", glb_addr, exp_q[0].addr);
                        check("wr_data", glb_wdata, exp_q[0].data);
                        check("wr_strb", {28'b0, glb_strb}, {28'b0, exp_q[0].strb});
                        if (!glb_ready) begin
                            check("in_ready_stall", {31'b0, in_ready}, 32'd0);
                        end else begin
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) exp_done_at = cyc + 1;
                        end
                    end
                end
                if (cyc == valid_due) check("word_latency", {31'b0, glb_valid}, 32'd1);
                if (done || cyc == exp_done_at)
                    check("done_timing", {31'b0, done}, {31'b0, (cyc == exp_done_at)});
                if (done) done_cnt++;
                if (!busy) check("in_ready_idle", {31'b0, in_ready}, 32'd0);
            end
        end
    end

    // mode 0: plain tile, 1: extra start pulse mid-tile, 2: reset after three bytes
    task automatic run_tile(input logic [31:0] base, input int n, input int mode, input int first);
        logic [7:0] b[$];
        int  k;
        int  t;
        int  budget;
        int  d0;
        bit  injected;
        wr_t e;
        injected = 1'b0;
        for (int i = 0; i < n; i++)
            b.push_back((first >= 0) ? 8'(first + i) : 8'($urandom));
        if (mode != 2) begin
            for (int w = 0; w * 4 < n; w++) begin
                e.addr = base + 32'(4 * w);
                e.data = '0;
                e.strb = '0;
                for (int j = 0; j < 4; j++) begin
                    if (4 * w + j < n) begin
                        e.data[8*j +: 8] = b[4*w + j];
                        e.strb[j] = 1'b1;
                    end
                end
`ifndef OFMAP_PACKER_PARTIAL_STRB_EN
                e.strb = 4'hF;
`endif
                exp_q.push_back(e);
            end
        end
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        total_bytes = 16'(n);
        t = cyc;
        if (n == 0) exp_done_at = t + 2;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = $urandom;
        total_bytes = 16'($urandom);
        if (n == 0) begin
            @(negedge clk);
            check("busy_after_start", {31'b0, busy}, 32'd1);
            check("in_ready_zero_tile", {31'b0, in_ready}, 32'd0);
        end
        k = 0;
        budget = 0;
        while (k < n && budget < 500) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = b[k];
            if (mode == 1 && k == 2 && !injected) begin
                start = 1'b1;
                base_addr = base + 32'h40;
                total_bytes = 16'd1;
                injected = 1'b1;
            end
            @(negedge clk);
            if (cyc == t + 1) begin
                check("busy_after_start", {31'b0, busy}, 32'd1);
                check("in_ready_after_start", {31'b0, in_ready}, 32'd1);
            end
            if (in_valid && in_ready) begin
                if (k % 4 == 3 || k == n - 1) valid_due = cyc + 1;
                k++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            in_valid = 1'b0;
            if (mode == 2 && k == 3) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_in_ready", {31'b0, in_ready}, 32'd0);
                check("rst_glb_valid", {31'b0, glb_valid}, 32'd0);
                check("rst_busy", {31'b0, busy}, 32'd0);
                check("rst_glb_addr", glb_addr, 32'd0);
                check("rst_glb_wdata", glb_wdata, 32'd0);
                check("rst_glb_strb", {28'b0, glb_strb}, 32'd0);
                repeat (4) @(negedge clk);
                check("rst_no_done", done_cnt - d0, 0);
                return;
            end
            budget++;
        end
        in_valid = 1'b0;
        if (k < n) check("feed_timeout", k, n);
        budget = 0;
        while (done_cnt == d0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        check("done_count", done_cnt - d0, 1);
        check("words_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        total_bytes = '0;
        in_valid = 1'b0;
        in_data = '0;
        w_start = 1'b0;
        w_base = '0;
        w_total = '0;
        w_in_valid = 1'b0;
        w_in_data = '0;
        w_glb_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_glb_valid", {31'b0, glb_valid}, 32'd0);
        check("reset_glb_addr", glb_addr, 32'd0);
        check("reset_glb_wdata", glb_wdata, 32'd0);
        check("reset_glb_strb", {28'b0, glb_strb}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        rmode = 0;
        run_tile(32'h100, 8, 0, 8'h01);
        run_tile(32'h100, 6, 0, 8'hA0);
        rmode = 2;
        stall_armed = 1'b1;
        run_tile(32'h200, 12, 0, -1);
        rmode = 0;
        run_tile(32'h300, 0, 0, -1);
        run_tile(32'h400, 10, 1, -1);
        run_tile(32'h500, 8, 2, -1);
        run_tile(32'h600, 8, 0, -1);
        rmode = 1;
        repeat (25) run_tile({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 13), 0, -1);
        run_tile(32'hFFFF_FFF8, 9, 0, -1);

        // Address wrap on an 8-bit address instance
        rmode = 0;
        wn = 0;
        wk = 0;
        @(posedge clk);
        #1;
        w_start = 1'b1;
        w_base = 8'hFC;
        w_total = 16'd8;
        @(posedge clk);
        #1;
        w_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            w_in_valid = (wk < 8);
            w_in_data = 8'h10 + 8'(wk);
            @(negedge clk);
            if (w_glb_valid && w_glb_ready) begin
                if (wn < 2) begin
                    wa[wn] = w_glb_addr;
                    wd[wn] = w_glb_wdata;
                end
                wn++;
            end
            if (w_in_valid && w_in_ready) wk++;
            @(posedge clk);
            #1;
        end
        w_in_valid = 1'b0;
        check("wrap_writes", wn, 2);
        check("wrap_addr0", {24'b0, wa[0]}, 32'h0000_00FC);
        check("wrap_addr1", {24'b0, wa[1]}, 32'h0000_0000);
        check("wrap_data0", wd[0], 32'h1312_1110);
        check("wrap_data1", wd[1], 32'h1716_1514);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
